// File: rtl/sound_generator_mc.sv
// sound_generator_mc: multi-channel square-wave sound generator with
// shared LFO/noise sources, per-channel mixer and decaying envelope.
module sound_generator_mc #(
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 16,
    parameter int VCO_W    = 12,
    parameter int LFO_W    = 10,
    parameter int ENV_W    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CHANNELS*VCO_W-1:0]            vco_freq,
    input  logic [CHANNELS-1:0]                  vco_select,
    input  logic [LFO_W-1:0]                     lfo_freq,
    input  logic [VCO_W-1:0]                     noise_freq,
    input  logic                                 noise_select,
    input  logic [2:0]                           lfo_shift,
    input  logic [CHANNELS*3-1:0]                mixer,
    input  logic [CHANNELS-1:0]                  trigger,
    input  logic [CHANNELS*8-1:0]                env_decay,
    output logic [ENV_W+$clog2(CHANNELS)-1:0]    audio,
    output logic [CHANNELS-1:0]                  busy
);

    localparam int PW  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int LCW = LFO_W + 8;
    localparam int CW  = VCO_W + 1;
    localparam int AW  = ENV_W + $clog2(CHANNELS);
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    logic [PW-1:0]                  presc_q, presc_d;
    logic                           tick;
    logic [LCW-1:0]                 lfo_cnt_q, lfo_cnt_d;
    logic                           lfo_st_q, lfo_st_d;
    logic [VCO_W-1:0]               tri_raw, tri_w, delta;
    logic [CHANNELS-1:0][CW-1:0]    vco_cnt_q, vco_cnt_d;
    logic [CHANNELS-1:0]            vco_st_q, vco_st_d;
    logic [CW-1:0]                  noise_cnt_q, noise_cnt_d, noise_rl;
    logic                           noise_st_q, noise_st_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [CHANNELS-1:0][7:0]       decay;
    logic [CHANNELS-1:0][ENV_W-1:0] env_q, env_d;
    logic [CHANNELS-1:0][7:0]       dcnt_q, dcnt_d;
    logic [CHANNELS-1:0]            pend_q, pend_d, trig_eff;
    logic [CHANNELS-1:0]            gate;
    logic [AW-1:0]                  sum_w;
    logic [AW-1:0]                  audio_q, audio_d;
    logic [CHANNELS-1:0]            busy_q, busy_d;

    assign tick    = (presc_q == '0);
    assign presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);

    // Triangle is the top of the LFO count, folded when the MSB is set
    assign tri_raw = lfo_cnt_q[LCW-1 -: VCO_W];
    assign tri_w   = lfo_cnt_q[LCW-1] ? ~tri_raw : tri_raw;
    assign delta   = tri_w >> lfo_shift;

    assign decay    = env_decay;
    assign trig_eff = pend_q | trigger;
    assign noise_rl = {1'b0, noise_freq} + (noise_select ? {1'b0, delta} : '0);

    // LFO down-counter with half-period reload and square state
    always_comb begin
        lfo_cnt_d = lfo_cnt_q;
        lfo_st_d  = lfo_st_q;
        if (tick) begin
            if (lfo_cnt_q == '0) begin
                lfo_st_d  = ~lfo_st_q;
                lfo_cnt_d = {lfo_freq, 8'b0};
            end else begin
                lfo_cnt_d = lfo_cnt_q - LCW'(1);
            end
        end
    end

    // Per-channel VCOs, optionally stretched by the LFO triangle
    always_comb begin
        vco_cnt_d = vco_cnt_q;
        vco_st_d  = vco_st_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (vco_cnt_q[i] == '0) begin
                    vco_st_d[i]  = ~vco_st_q[i];
                    vco_cnt_d[i] = {1'b0, vco_freq[i*VCO_W +: VCO_W]}
                                 + (vco_select[i] ? {1'b0, delta} : '0);
                end else begin
                    vco_cnt_d[i] = vco_cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Noise: each reload steps the LFSR and toggles on a shifted-out one
    always_comb begin
        noise_cnt_d = noise_cnt_q;
        noise_st_d  = noise_st_q;
        lfsr_d      = lfsr_q;
        if (tick) begin
            if (noise_cnt_q == '0) begin
                noise_cnt_d = noise_rl;
                if (lfsr_q[0]) begin
                    noise_st_d = ~noise_st_q;
                end
                lfsr_d = {1'b0, lfsr_q[15:1]}
                       ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            end else begin
                noise_cnt_d = noise_cnt_q - CW'(1);
            end
        end
    end

    // Envelopes: triggers latch until the tick, then restart at max level
    always_comb begin
        env_d  = env_q;
        dcnt_d = dcnt_q;
        pend_d = pend_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!tick) begin
                pend_d[i] = trig_eff[i];
            end else begin
                pend_d[i] = 1'b0;
                if (trig_eff[i]) begin
                    env_d[i]  = ENV_MAX;
                    dcnt_d[i] = decay[i];
                end else if (env_q[i] != '0 && decay[i] != '0) begin
                    if (dcnt_q[i] == '0) begin
                        env_d[i]  = env_q[i] - ENV_W'(1);
                        dcnt_d[i] = decay[i];
                    end else begin
                        dcnt_d[i] = dcnt_q[i] - 8'd1;
                    end
                end
            end
        end
    end

    // Mixer gates and exact channel sum from pre-tick state
    always_comb begin
        gate   = '0;
        sum_w  = '0;
        busy_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gate[i] = (lfo_st_q   | ~mixer[i*3+2])
                    & (noise_st_q | ~mixer[i*3+1])
                    & (vco_st_q[i] | ~mixer[i*3]);
            if (gate[i]) begin
                sum_w = sum_w + AW'(env_q[i]);
            end
            busy_d[i] = (env_d[i] != '0);
        end
        audio_d = tick ? sum_w : audio_q;
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            lfo_cnt_q   <= '0;
            lfo_st_q    <= 1'b0;
            vco_cnt_q   <= '0;
            vco_st_q    <= '0;
            noise_cnt_q <= '0;
            noise_st_q  <= 1'b0;
            lfsr_q      <= 16'h0001;
            env_q       <= '0;
            dcnt_q      <= '0;
            pend_q      <= '0;
            audio_q     <= '0;
            busy_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            lfo_cnt_q   <= lfo_cnt_d;
            lfo_st_q    <= lfo_st_d;
            vco_cnt_q   <= vco_cnt_d;
            vco_st_q    <= vco_st_d;
            noise_cnt_q <= noise_cnt_d;
            noise_st_q  <= noise_st_d;
            lfsr_q      <= lfsr_d;
            env_q       <= env_d;
            dcnt_q      <= dcnt_d;
            pend_q      <= pend_d;
            audio_q     <= audio_d;
            busy_q      <= busy_d;
        end
    end

    assign audio = audio_q;
    assign busy  = busy_q;

endmodule
